// File: rtl/alu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_core : 16-bit ALU, single-cycle ops plus iterative shift-add multiply |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module alu_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] result,
    output logic        zero,
    output logic        carry,
    output logic        busy,
    output logic        done
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    logic [0:0]  state;
    logic [0:0]  state_next;
    logic [31:0] mcand;
    logic [15:0] mplier;
    logic [31:0] acc;
    logic [31:0] acc_next;
    logic [3:0]  cnt;
    logic        mul_last;
    logic [15:0] alu_res;
    logic        alu_c;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [16:0] shl_ext;
    logic [16:0] shr_ext;

    // Single-cycle datapath; the extra bit of each shift catches the last bit out
    always_comb begin
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        shl_ext = {1'b0, a} << b[3:0];
        shr_ext = {a, 1'b0} >> b[3:0];
        alu_res = 16'h0000;
        alu_c   = 1'b0;
        case (op)
            OP_ADD: begin alu_res = sum[15:0];     alu_c = sum[16];     end
            OP_SUB: begin alu_res = diff[15:0];    alu_c = diff[16];    end
            OP_AND: begin alu_res = a & b;                              end
            OP_OR:  begin alu_res = a | b;                              end
            OP_XOR: begin alu_res = a ^ b;                              end
            OP_SHL: begin alu_res = shl_ext[15:0]; alu_c = shl_ext[16]; end
            OP_SHR: begin alu_res = shr_ext[16:1]; alu_c = shr_ext[0];  end
            default: begin alu_res = 16'h0000;     alu_c = 1'b0;        end
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : 32'd0);
    assign mul_last = (cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start && op == OP_MUL) state_next = S_MUL;
            S_MUL:   if (mul_last) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_MUL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= 16'h0000;
            zero   <= 1'b1;
            carry  <= 1'b0;
            done   <= 1'b0;
            mcand  <= 32'd0;
            mplier <= 16'h0000;
            acc    <= 32'd0;
            cnt    <= 4'd0;
        end else begin
            done <= 1'b0;
            if (state == S_IDLE) begin
                if (start) begin
                    if (op == OP_MUL) begin
                        mcand  <= {16'h0000, a};
                        mplier <= b;
                        acc    <= 32'd0;
                        cnt    <= 4'd0;
                    end else begin
                        result <= alu_res;
                        zero   <= (alu_res == 16'h0000);
                        carry  <= alu_c;
                        done   <= 1'b1;
                    end
                end
            end else begin
                // One multiplier bit per cycle, LSB first; outputs only move on the last one
                acc    <= acc_next;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 4'd1;
                if (mul_last) begin
                    result <= acc_next[15:0];
                    zero   <= (acc_next[15:0] == 16'h0000);
                    carry  <= |acc_next[31:16];
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_core.sv
`default_nettype none
// tb_alu_core : directed and randomized checks of alu_core against an arithmetic reference model.
module tb_alu_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [15:0] a = 16'h0000;
    logic [15:0] b = 16'h0000;
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] held_res   = 16'h0000;
    logic        held_zero  = 1'b1;
    logic        held_carry = 1'b0;

    alu_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .result (result),
        .zero   (zero),
        .carry  (carry),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain unsigned arithmetic on wide integers
    function automatic void model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic c);
        longint unsigned p;
        int unsigned     n;
        n = int'(y[3:0]);
        p = 0;
        c = 1'b0;
        case (o)
            3'd0: begin p = longint'(x) + longint'(y); c = (p > 65535); end
            3'd1: begin p = (longint'(x) + 65536 - longint'(y)) % 65536; c = (x < y); end
            3'd2: p = longint'(x & y);
            3'd3: p = longint'(x | y);
            3'd4: p = longint'(x ^ y);
            3'd5: begin p = longint'(x) << n; c = (n != 0) && (((p >> 16) % 2) == 1); end
            3'd6: begin p = longint'(x) >> n; c = (n != 0) && (((longint'(x) >> (n - 1)) % 2) == 1); end
            default: begin p = longint'(x) * longint'(y); c = (p > 65535); end
        endcase
        r = 16'(p % 65536);
    endfunction

    task automatic check_result(input string tag, input logic [15:0] er, input logic ec);
        check({tag, ".result"}, result, er);
        check({tag, ".zero"},   zero,   (er == 16'h0000));
        check({tag, ".carry"},  carry,  ec);
    endtask

    task automatic check_held(input string tag);
        check({tag, ".hold_res"},   result, held_res);
        check({tag, ".hold_zero"},  zero,   held_zero);
        check({tag, ".hold_carry"}, carry,  held_carry);
    endtask

    // Issue one operation, follow it to completion, then confirm done drops
    task automatic run_op(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                          input string tag, input bit inject);
        logic [15:0] er;
        logic        ec;
        model(o, x, y, er, ec);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); a = 16'($urandom); b = 16'($urandom);
        if (o != 3'b111) begin
            check({tag, ".done"}, done, 1);
            check({tag, ".busy"}, busy, 0);
            check_result(tag, er, ec);
        end else begin
            check({tag, ".busy0"}, busy, 1);
            check({tag, ".done0"}, done, 0);
            check_held({tag, ".e0"});
            for (int i = 1; i <= 16; i++) begin
                if (inject && i == 5) begin
                    start = 1'b1; op = 3'b000; a = 16'h1111; b = 16'h2222;
                end
                @(posedge clk); #1;
                start = 1'b0;
                if (i < 16) begin
                    check({tag, ".busy_it"}, busy, 1);
                    check({tag, ".done_it"}, done, 0);
                    check_held({tag, ".it"});
                end
            end
            check({tag, ".done"}, done, 1);
            check({tag, ".busy"}, busy, 0);
            check_result(tag, er, ec);
        end
        held_res = er; held_zero = (er == 16'h0000); held_carry = ec;
        @(posedge clk); #1;
        check({tag, ".done_drop"}, done, 0);
        check({tag, ".busy_idle"}, busy, 0);
        check_held({tag, ".after"});
    endtask

    initial begin
        logic [15:0] er1, er2;
        logic        ec1, ec2;
        logic [2:0]  ro;
        logic [15:0] rx, ry;

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset.result", result, 16'h0000);
        check("reset.zero",   zero,   1);
        check("reset.carry",  carry,  0);
        check("reset.busy",   busy,   0);
        check("reset.done",   done,   0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed single-cycle cases
        run_op(3'b000, 16'hFFFF, 16'h0001, "add_wrap", 0);
        run_op(3'b001, 16'h0003, 16'h0005, "sub_borrow", 0);
        run_op(3'b101, 16'h8001, 16'h0001, "shl_out", 0);
        run_op(3'b101, 16'hABCD, 16'h0010, "shl_zero_amt", 0);
        run_op(3'b110, 16'h8001, 16'h000F, "shr_15", 0);
        run_op(3'b110, 16'h1234, 16'h0000, "shr_zero_amt", 0);

        // Multiply cases
        run_op(3'b111, 16'h0012, 16'h0034, "mul_small", 0);
        run_op(3'b111, 16'h0100, 16'h0100, "mul_ovf", 0);
        run_op(3'b111, 16'h00FF, 16'h0101, "mul_inject", 1);

        // Reset during multiply
        @(negedge clk);
        start = 1'b1; op = 3'b111; a = 16'h1234; b = 16'h5678;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mul.result", result, 16'h0000);
        check("rst_mul.zero",   zero,   1);
        check("rst_mul.carry",  carry,  0);
        check("rst_mul.busy",   busy,   0);
        check("rst_mul.done",   done,   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        held_res = 16'h0000; held_zero = 1'b1; held_carry = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("rst_mul.no_done", done, 0);
            check("rst_mul.idle",    busy, 0);
        end
        run_op(3'b000, 16'h0002, 16'h0003, "add_after_rst", 0);

        // Back-to-back ADD then XOR
        model(3'b000, 16'h1234, 16'h4321, er1, ec1);
        model(3'b100, 16'hAAAA, 16'hFFFF, er2, ec2);
        @(negedge clk);
        start = 1'b1; op = 3'b000; a = 16'h1234; b = 16'h4321;
        @(posedge clk); #1;
        check("b2b.done1", done, 1);
        check_result("b2b.first", er1, ec1);
        op = 3'b100; a = 16'hAAAA; b = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.done2", done, 1);
        check_result("b2b.second", er2, ec2);
        @(posedge clk); #1;
        check("b2b.done_drop", done, 0);
        held_res = er2; held_zero = (er2 == 16'h0000); held_carry = ec2;

        // Randomized operations
        for (int k = 0; k < 40; k++) begin
            ro = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: rx = 16'hFFFF;
                1: rx = 16'h0000;
                default: rx = 16'($urandom);
            endcase
            ry = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
            run_op(ro, rx, ry, "rand", ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
